// File: rtl/enc_pos_ctrl.sv
// N-channel quadrature encoder position block: 2-FF sync, debounce, step decode, wrap/saturate, button zero.
// Input edge to pos update is fixed at DB_CYCLES+3 cycles; read port answers one cycle after rd_en; no backpressure.
module enc_pos_ctrl #(
    parameter int                      NUM_CH    = 3,
    parameter int                      CNT_W     = 8,
    parameter logic [NUM_CH*CNT_W-1:0] MAX_VEC   = {8'd255, 8'd119, 8'd159},
    parameter bit                      WRAP      = 1'b1,
    parameter int                      DB_CYCLES = 1000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_CH-1:0]       enc_a,
    input  logic [NUM_CH-1:0]       enc_b,
    input  logic [NUM_CH-1:0]       enc_btn,
    input  logic                    rd_en,
    input  logic [3:0]              rd_addr,
    output logic [15:0]             rd_data,
    output logic                    rd_valid,
    output logic [NUM_CH*CNT_W-1:0] pos_bus,
    output logic [NUM_CH-1:0]       changed
);
    // Filtered signal vector layout: [A | B | BTN], A in the low NUM_CH bits.
    localparam int              NS      = 3 * NUM_CH;
    localparam int              DBW     = $clog2(DB_CYCLES + 1);
    localparam logic [DBW-1:0]  DB_LAST = DBW'(DB_CYCLES - 1);
    localparam logic [NS-1:0]   RST_VAL = {{NUM_CH{1'b0}}, {(2*NUM_CH){1'b1}}};

    logic [NS-1:0]           w_raw;
    logic [NS-1:0]           r_sync1;
    logic [NS-1:0]           r_sync2;
    logic [NS-1:0]           r_filt;
    logic [DBW-1:0]          r_cnt [NS];
    logic [NUM_CH-1:0]       r_a_prev;
    logic [NUM_CH-1:0]       r_btn_prev;
    logic [NUM_CH*CNT_W-1:0] r_pos;
    logic [NUM_CH*CNT_W-1:0] w_pos_nxt;
    logic [NUM_CH-1:0]       w_chg;
    logic [NUM_CH-1:0]       r_changed;
    logic [NUM_CH-1:0]       w_clr;
    logic [15:0]             w_rd_mux;
    logic [15:0]             r_rd_data;
    logic                    r_rd_valid;

    assign w_raw = {enc_btn, enc_b, enc_a};

    genvar g;
    for (g = 0; g < NUM_CH; g++) begin : g_ch
        localparam logic [CNT_W-1:0] M = MAX_VEC[g*CNT_W +: CNT_W];
        logic [CNT_W-1:0] w_cur;
        logic [CNT_W-1:0] w_nxt;
        logic             w_a_rise;
        logic             w_btn_rise;
        logic             w_dn;

        assign w_cur      = r_pos[g*CNT_W +: CNT_W];
        assign w_a_rise   = r_filt[g] & ~r_a_prev[g];
        assign w_btn_rise = r_filt[2*NUM_CH+g] & ~r_btn_prev[g];
        assign w_dn       = r_filt[NUM_CH+g];

        // Button edge takes priority over a coincident step.
        always_comb begin
            w_nxt = w_cur;
            if (w_btn_rise) begin
                w_nxt = '0;
            end else if (w_a_rise) begin
                if (!w_dn) begin
                    if (w_cur >= M) w_nxt = WRAP ? '0 : M;
                    else            w_nxt = w_cur + 1'b1;
                end else begin
                    if (w_cur == '0) w_nxt = WRAP ? M : '0;
                    else             w_nxt = w_cur - 1'b1;
                end
            end
        end

        assign w_pos_nxt[g*CNT_W +: CNT_W] = w_nxt;
        assign w_chg[g]                    = (w_nxt != w_cur);
    end

    always_comb begin
        w_rd_mux = '0;
        w_clr    = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (rd_addr == 4'(i)) w_rd_mux = 16'(r_pos[i*CNT_W +: CNT_W]);
        end
        if (rd_addr == 4'(NUM_CH)) begin
            w_rd_mux = 16'(r_changed);
            if (rd_en) w_clr = r_changed;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1    <= RST_VAL;
            r_sync2    <= RST_VAL;
            r_filt     <= RST_VAL;
            for (int i = 0; i < NS; i++) r_cnt[i] <= '0;
            r_a_prev   <= '1;
            r_btn_prev <= '0;
            r_pos      <= '0;
            r_changed  <= '0;
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            r_sync1    <= w_raw;
            r_sync2    <= r_sync1;
            for (int i = 0; i < NS; i++) begin
                if (r_sync2[i] == r_filt[i]) begin
                    r_cnt[i] <= '0;
                end else if (r_cnt[i] == DB_LAST) begin
                    r_filt[i] <= r_sync2[i];
                    r_cnt[i]  <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + 1'b1;
                end
            end
            r_a_prev   <= r_filt[NUM_CH-1:0];
            r_btn_prev <= r_filt[NS-1:2*NUM_CH];
            r_pos      <= w_pos_nxt;
            // A flag setting in the read cycle survives the read-clear.
            r_changed  <= (r_changed & ~w_clr) | w_chg;
            r_rd_valid <= rd_en;
            if (rd_en) r_rd_data <= w_rd_mux;
        end
    end

    assign pos_bus  = r_pos;
    assign changed  = r_changed;
    assign rd_data  = r_rd_data;
    assign rd_valid = r_rd_valid;

endmodule

// File: tb/tb_enc_pos_ctrl.sv
// Bench for enc_pos_ctrl: a wrapping and a saturating instance share stimulus; an event-level model predicts both.
`timescale 1ns/1ps
module tb_enc_pos_ctrl;
    localparam int DB = 4;
    localparam int MAXV [3] = '{159, 119, 255};

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  enc_a, enc_b, enc_btn;
    logic        rd_en;
    logic [3:0]  rd_addr;
    logic [15:0] rd_data_w, rd_data_s;
    logic        rd_valid_w, rd_valid_s;
    logic [23:0] pos_w, pos_s;
    logic [2:0]  chg_w, chg_s;

    int          checks = 0;
    int          errors = 0;
    int          mpos [2][3];
    logic [2:0]  mchg [2];
    int          lat = 7;

    always #5 clk = ~clk;

    enc_pos_ctrl #(.NUM_CH(3), .CNT_W(8), .MAX_VEC({8'd255, 8'd119, 8'd159}),
                   .WRAP(1'b1), .DB_CYCLES(DB)) dut_w (
        .clk(clk), .rst(rst), .enc_a(enc_a), .enc_b(enc_b), .enc_btn(enc_btn),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_w), .rd_valid(rd_valid_w),
        .pos_bus(pos_w), .changed(chg_w));

    enc_pos_ctrl #(.NUM_CH(3), .CNT_W(8), .MAX_VEC({8'd255, 8'd119, 8'd159}),
                   .WRAP(1'b0), .DB_CYCLES(DB)) dut_s (
        .clk(clk), .rst(rst), .enc_a(enc_a), .enc_b(enc_b), .enc_btn(enc_btn),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_s), .rd_valid(rd_valid_s),
        .pos_bus(pos_s), .changed(chg_s));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            for (int c = 0; c < 3; c++) mpos[d][c] = 0;
            mchg[d] = 3'b000;
        end
    endtask

    // d=0 wraps, d=1 saturates.
    task automatic model_step(input int ch, input int dir);
        int nv;
        for (int d = 0; d < 2; d++) begin
            nv = mpos[d][ch] + dir;
            if (nv > MAXV[ch]) nv = (d == 0) ? 0 : MAXV[ch];
            if (nv < 0)        nv = (d == 0) ? MAXV[ch] : 0;
            if (nv != mpos[d][ch]) mchg[d][ch] = 1'b1;
            mpos[d][ch] = nv;
        end
    endtask

    task automatic model_zero(input int ch);
        for (int d = 0; d < 2; d++) begin
            if (mpos[d][ch] != 0) mchg[d][ch] = 1'b1;
            mpos[d][ch] = 0;
        end
    endtask

    task automatic check_all(input string tag);
        for (int c = 0; c < 3; c++) begin
            chk($sformatf("%s pos_w[%0d]", tag, c), 32'(pos_w[c*8 +: 8]), mpos[0][c]);
            chk($sformatf("%s pos_s[%0d]", tag, c), 32'(pos_s[c*8 +: 8]), mpos[1][c]);
        end
        chk($sformatf("%s changed_w", tag), 32'(chg_w), 32'(mchg[0]));
        chk($sformatf("%s changed_s", tag), 32'(chg_s), 32'(mchg[1]));
    endtask

    // One detent: optional B setup, A fall, A rise, B back to idle.
    task automatic step(input int ch, input int dir, input bit meas);
        int k;
        logic [7:0] old;
        enc_b[ch] = (dir < 0);
        tick(8);
        enc_a[ch] = 1'b0;
        tick(8);
        old = pos_w[ch*8 +: 8];
        enc_a[ch] = 1'b1;
        if (meas) begin
            k = 0;
            while (k < 12) begin
                tick(1);
                k++;
                if (pos_w[ch*8 +: 8] != old) break;
            end
            chk("latency 6..8", 32'(k >= 6 && k <= 8), 32'd1);
            if (k >= 6 && k <= 8) lat = k;
            if (k < 10) tick(10 - k);
        end else begin
            tick(10);
        end
        enc_b[ch] = 1'b1;
        tick(8);
        model_step(ch, dir);
    endtask

    task automatic press(input int ch);
        enc_btn[ch] = 1'b1;
        tick(10);
        enc_btn[ch] = 1'b0;
        tick(10);
        model_zero(ch);
    endtask

    task automatic glitch(input int ch, input bit on_btn, input int len);
        if (on_btn) enc_btn[ch] = 1'b1;
        else        enc_a[ch]   = 1'b0;
        tick(len);
        if (on_btn) enc_btn[ch] = 1'b0;
        else        enc_a[ch]   = 1'b1;
        tick(10);
    endtask

    function automatic logic [15:0] rd_exp(input int d, input logic [3:0] addr);
        if (addr < 4'd3)  return 16'(mpos[d][addr]);
        if (addr == 4'd3) return 16'(mchg[d]);
        return 16'h0000;
    endfunction

    task automatic do_read(input logic [3:0] addr);
        logic [15:0] ew, es;
        ew = rd_exp(0, addr);
        es = rd_exp(1, addr);
        rd_addr = addr;
        rd_en   = 1'b1;
        tick(1);
        rd_en   = 1'b0;
        chk($sformatf("rd_valid_w a%0d", addr), 32'(rd_valid_w), 32'd1);
        chk($sformatf("rd_data_w a%0d", addr), 32'(rd_data_w), 32'(ew));
        chk($sformatf("rd_data_s a%0d", addr), 32'(rd_data_s), 32'(es));
        if (addr == 4'd3) begin
            mchg[0] = 3'b000;
            mchg[1] = 3'b000;
        end
        tick(1);
        chk("rd_valid_w idle", 32'(rd_valid_w), 32'd0);
        chk("rd_data_w hold", 32'(rd_data_w), 32'(ew));
        check_all($sformatf("after read a%0d", addr));
    endtask

    initial begin
        logic [15:0] ew, es;
        int op, ch;
        rst     = 1'b1;
        enc_a   = 3'b111;
        enc_b   = 3'b111;
        enc_btn = 3'b000;
        rd_en   = 1'b0;
        rd_addr = 4'd0;
        model_reset();
        tick(3);
        rst = 1'b0;
        chk("reset rd_valid", 32'(rd_valid_w), 32'd0);
        chk("reset rd_data", 32'(rd_data_w), 32'd0);
        check_all("reset");
        tick(20);
        check_all("idle");

        for (int i = 0; i < 5; i++) step(0, 1, 1'b1);
        check_all("ch0 five cw");
        do_read(4'd0);

        step(1, -1, 1'b0);
        check_all("ch1 ccw from 0");
        step(1, 1, 1'b0);
        check_all("ch1 cw");

        glitch(2, 1'b0, 3);
        check_all("ch2 a glitch");
        glitch(2, 1'b1, 3);
        check_all("ch2 btn glitch");

        for (int i = 0; i < 10; i++) step(2, 1, 1'b0);
        check_all("ch2 at 10");
        enc_b[2] = 1'b0;
        tick(8);
        enc_a[2] = 1'b0;
        tick(8);
        enc_a[2]   = 1'b1;
        enc_btn[2] = 1'b1;
        tick(10);
        model_zero(2);
        check_all("btn beats step");
        enc_a[2] = 1'b0;
        tick(8);
        enc_a[2] = 1'b1;
        tick(10);
        model_step(2, 1);
        check_all("step while btn held");
        enc_btn[2] = 1'b0;
        enc_b[2]   = 1'b1;
        tick(10);
        check_all("btn release");

        do_read(4'd3);
        step(0, 1, 1'b0);
        step(2, 1, 1'b0);
        do_read(4'd3);

        // Flag set on ch1 lands on the same edge as a changed-read clear.
        step(0, 1, 1'b0);
        step(2, 1, 1'b0);
        enc_b[1] = 1'b0;
        tick(8);
        enc_a[1] = 1'b0;
        tick(8);
        enc_a[1] = 1'b1;
        tick(lat - 1);
        ew = rd_exp(0, 4'd3);
        es = rd_exp(1, 4'd3);
        rd_addr = 4'd3;
        rd_en   = 1'b1;
        tick(1);
        rd_en   = 1'b0;
        chk("set-vs-clr rd_data_w", 32'(rd_data_w), 32'(ew));
        chk("set-vs-clr rd_data_s", 32'(rd_data_s), 32'(es));
        mchg[0] = 3'b000;
        mchg[1] = 3'b000;
        model_step(1, 1);
        check_all("set beats clear");
        tick(8);
        enc_b[1] = 1'b1;
        tick(8);
        check_all("set beats clear settle");

        do_read(4'd9);

        enc_b[0] = 1'b0;
        tick(8);
        enc_a[0] = 1'b0;
        tick(8);
        enc_a[0] = 1'b1;
        tick(3);
        rst     = 1'b1;
        rd_addr = 4'd0;
        rd_en   = 1'b1;
        tick(1);
        rd_en   = 1'b0;
        tick(1);
        rst = 1'b0;
        model_reset();
        chk("rst during read valid", 32'(rd_valid_w), 32'd0);
        chk("rst during read data", 32'(rd_data_w), 32'd0);
        check_all("rst mid-detent");
        tick(20);
        check_all("after rst release");
        enc_b[0] = 1'b1;
        tick(10);
        check_all("after rst idle");

        for (int it = 0; it < 40; it++) begin
            op = int'($urandom_range(0, 5));
            ch = int'($urandom_range(0, 2));
            case (op)
                0, 1: step(ch, 1, 1'b0);
                2:    step(ch, -1, 1'b0);
                3:    press(ch);
                4:    glitch(ch, 1'($urandom_range(0, 1)), int'($urandom_range(1, DB - 1)));
                default: do_read(4'($urandom_range(0, 15)));
            endcase
            check_all($sformatf("rand %0d op %0d ch %0d", it, op, ch));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/enc_pos_ctrl.md
Name: enc_pos_ctrl

Overview:
Parametrised N-channel rotary-encoder position block. It generalises the fixed three-instance encoder hookup into one block with several additions: input synchronisation and debounce, a per-channel maximum, wrap or saturate mode, a zero-on-button action, per-channel change flags, and a registered read port for the memory controller. It sits between the Pmod header pins and the memory controller's pixel/colour inputs. It also drives the seven-segment display through the packed position bus.

Parameters:
NUM_CH, 3, number of encoder channels (1..8)
CNT_W, 8, position counter width in bits (1..16)
MAX_VEC, {8'd255,8'd119,8'd159}, packed per-channel maximum; channel i at [i*CNT_W +: CNT_W]; each value must be >= 1
WRAP, 1, 1 = wrap at the limits, 0 = saturate at the limits
DB_CYCLES, 1000, consecutive stable cycles required before a filtered input changes (>= 1)

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
enc_a  in  NUM_CH  encoder A lines, asynchronous
enc_b  in  NUM_CH  encoder B lines, asynchronous
enc_btn  in  NUM_CH  encoder push-buttons, asynchronous, active-high
rd_en  in  1  read strobe
rd_addr  in  4  read address
rd_data  out  16  registered read data
rd_valid  out  1  high one cycle after rd_en
pos_bus  out  NUM_CH*CNT_W  live positions; channel i at [i*CNT_W +: CNT_W]
changed  out  NUM_CH  sticky per-channel change flags

Behaviour:
- Reset (rst high at a clk edge):
  - pos 0 for all channels; changed 0; rd_data 0; rd_valid 0.
  - Synchroniser and filtered A/B set to 1 (idle high); filtered btn set to 0; debounce counters 0.
- Synchronisation: every input passes through a 2-FF synchroniser.
- Debounce, per signal:
  - While the synced value equals the filtered value, the counter clears.
  - Otherwise the counter increments. When it reaches DB_CYCLES, the filtered value takes the synced value and the counter clears.
  - A glitch shorter than DB_CYCLES never reaches the filtered value.
- Decode, per channel:
  - On a filtered-A rising edge (previous 0, current 1): filtered B = 0 gives step +1; filtered B = 1 gives step -1.
  - Exactly one step per A rising edge. A falling edges are ignored.
- Latency: pos changes between DB_CYCLES+2 and DB_CYCLES+4 cycles after a clean input edge. The implementation must be fixed, not variable.
- Counter arithmetic (CNT_W bits, M = channel maximum):
  - +1 at M: becomes 0 if WRAP, holds M if not.
  - -1 at 0: becomes M if WRAP, holds 0 if not.
  - If pos > M (never reachable after reset), the next +1 yields 0 (WRAP) or M (saturate).
- Button: a filtered-btn rising edge sets pos to 0.
  - If a button edge and a step occur in the same cycle, the button wins.
  - Holding the button does nothing further.
- Change flags:
  - changed[i] sets on any cycle in which pos[i] takes a different value.
  - A saturated hold, or a button press while already at 0, does not set it.
- Read port (1-cycle latency): rd_en in cycle t gives rd_data and rd_valid in cycle t+1.
  - rd_addr < NUM_CH: rd_data = zero-extended pos[rd_addr] as of cycle t.
  - rd_addr == NUM_CH: rd_data = zero-extended changed as of cycle t. All flags sampled as 1 clear at t+1. A flag that sets in cycle t remains set (set beats clear).
  - Any other address: rd_data = 0, no side effects.
  - rd_en low: rd_data holds its last value and rd_valid = 0.
  - Back-to-back reads are allowed every cycle.
- Reset during a read or mid-debounce: reset wins; no pending read completes.

Test Plan:
- DB_CYCLES=4, defaults: after rst, check pos_bus=0, changed=0, rd_valid=0. Hold A/B high for 20 cycles -> no step.
- Channel 0, five clean CW detents (A rises with B=0) -> pos0 = 5, changed = 3'b001. Each update lands 6–8 cycles after the edge.
- Channel 1 (M=119), 1 CCW detent from 0 with WRAP=1 -> 119, then 1 CW -> 0. Same with WRAP=0 -> stays 0 and changed[1] stays 0.
- 3-cycle glitch on channel 2 A -> no step. Button edge coincident with a step on channel 2 at pos 10 -> pos2 = 0.
- Read addr 0 at pos0=5 -> next cycle rd_data=16'h0005, rd_valid=1. Read addr 3 with changed=3'b101 -> rd_data=16'h0005 and flags clear. A step on ch1 during that read cycle -> changed=3'b010 afterwards.
- Read addr 9 -> rd_data=0, flags unchanged. rst asserted mid-detent -> all zeros, and no step after release.
